k423_wb_stage: RTL and testbench
================================

Name: k423_wb_stage

Overview:
- Writeback stage of the k423 pipeline and the producer side of the ID regfile interface.
- Accepts completed instructions from the MEM stage over a valid/ready handshake.
- For loads, waits for the data-memory response, then byte-aligns and sign- or zero-extends the load data.
- Drives the regfile write port and the WB forwarding port, plus a load-pending indication that ID uses for hazard stalls.

Parameters:
- XLEN, 32, data width (matches `CORE_XLEN)
- IDX_W, 5, register index width (matches `INST_RSDIDX_W)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- mem_vld_i  in  1  MEM stage has an instruction
- mem_rdy_o  out  1  WB can accept
- mem_rd_vld_i  in  1  instruction writes rd
- mem_rd_idx_i  in  IDX_W  destination index
- mem_rd_data_i  in  XLEN  ALU/CSR result (non-load)
- mem_load_i  in  1  instruction is a load
- mem_load_size_i  in  `LS_SIZE_W  BYTE/HALF/WORD
- mem_load_uns_i  in  1  zero-extend (LBU/LHU)
- mem_addr_lo_i  in  2  load address bits [1:0]
- dmem_rsp_vld_i  in  1  load response valid
- dmem_rsp_data_i  in  XLEN  raw aligned word from memory
- wb_rd_vld_o  out  1  regfile write enable
- wb_rd_idx_o  out  IDX_W  regfile write index
- wb_rd_data_o  out  XLEN  regfile write data
- wb_fwd_rd_vld_o  out  1  forward valid
- wb_fwd_rd_idx_o  out  IDX_W  forward index
- wb_fwd_rd_data_o  out  XLEN  forward data
- wb_ld_pend_o  out  1  load waiting for response
- wb_ld_pend_idx_o  out  IDX_W  rd of pending load
- wb_retire_o  out  1  one-cycle pulse per retired instruction

Behaviour:
- FSM states: S_IDLE, S_WB, S_LD_WAIT. Reset → S_IDLE. All outputs are 0 at reset and all internal registers are cleared. Reset asserted mid-operation aborts any pending load; a response arriving after reset is ignored.
- mem_rdy_o = (state != S_LD_WAIT). This gives back-to-back acceptance, so S_WB retires while a new instruction is accepted in the same cycle.
- On accept (mem_vld_i & mem_rdy_o), latch rd_vld, idx, data, load, size, uns and addr_lo. Then:
  - load=0 → S_WB
  - load=1 → S_LD_WAIT
- No accept while in S_WB → S_IDLE.
- S_LD_WAIT:
  - wb_ld_pend_o=1 and wb_ld_pend_idx_o = latched idx, only if rd_vld=1 and idx≠0; otherwise both are 0.
  - dmem_rsp_vld_i is sampled only in this state; the earliest valid response is the cycle after acceptance. Responses in any other state are ignored.
  - On a response, store the formatted load data into the data register → S_WB.
  - There is no timeout; the stage holds indefinitely.
- Load format:
  - BYTE selects byte addr_lo (bits [8*a+7:8*a]).
  - HALF selects the half at addr_lo[1]; addr_lo[0] is ignored (misalignment is trapped upstream).
  - WORD passes the word through; addr_lo is ignored.
  - Sign extension applies unless uns=1. uns is ignored for WORD.
- S_WB, the commit cycle:
  - wb_rd_vld_o = wb_fwd_rd_vld_o = latched rd_vld & (idx≠0).
  - Index and data outputs carry the latched values and are 0 whenever the corresponding valid is 0.
  - wb_retire_o=1, including for rd_vld=0 and x0 writes.
  - Write and forward are asserted in the same cycle, because ID reads the regfile combinationally before the write edge.
- Total latency:
  - non-load: accept edge → 1 cycle in S_WB.
  - load: accept → response edge → 1 cycle in S_WB.
- Write, forward and retire outputs are combinational decodes of registered state only. Apart from mem_rdy_o, nothing depends combinationally on inputs.

Test Plan:
- Reset, then ADD with rd=x5, data=0x0000_1234 → the next cycle shows wb_rd_vld_o=1, idx=5, data=0x1234, fwd equal, retire=1; the following cycle all outputs are 0.
- Three back-to-back non-loads (x1=1, x2=2, x3=3) with mem_vld_i held → mem_rdy_o stays 1; three consecutive commit cycles in order with no bubbles.
- LB x7, addr_lo=3, rsp 0x80FF_0000 delivered 2 cycles after accept → pend=1 with idx=7 for those cycles and mem_rdy_o=0; the commit writes 0xFFFF_FF80. Repeat with LBU → 0x0000_0080.
- LH addr_lo=2, rsp 0x8001_7FFF → 0xFFFF_8001. LHU addr_lo=0 → 0x0000_7FFF. LW → 0x8001_7FFF.
- Writes to x0 (ALU and load), and rd_vld=0 → wb_rd_vld_o=0, fwd_vld=0, pend=0, retire=1. A stray dmem_rsp_vld_i in S_IDLE → no effect.
- Load accepted, rst_n_i pulsed low before the response, response then arrives → no write, state S_IDLE, mem_rdy_o=1.

Source files
------------

// File: rtl/k423_wb_stage_if.sv
// k423_wb_stage_if
// Purpose: groups the MEM->WB instruction handshake and the data-memory load
// response that feed the k423 writeback stage.
// Signals:
//   mem_vld_i        MEM stage has an instruction
//   mem_rdy_o        WB can accept
//   mem_rd_vld_i     instruction writes rd
//   mem_rd_idx_i     destination index
//   mem_rd_data_i    ALU/CSR result (non-load)
//   mem_load_i       instruction is a load
//   mem_load_size_i  0=BYTE, 1=HALF, 2=WORD
//   mem_load_uns_i   zero-extend (LBU/LHU)
//   mem_addr_lo_i    load address bits [1:0]
//   dmem_rsp_vld_i   load response valid
//   dmem_rsp_data_i  raw aligned word from memory
// Modports: master = MEM/dmem side, slave = WB stage.
interface k423_wb_stage_if #(
  parameter int XLEN      = 32,
  parameter int IDX_W     = 5,
  parameter int LS_SIZE_W = 2
);

  logic                 mem_vld_i;
  logic                 mem_rdy_o;
  logic                 mem_rd_vld_i;
  logic [IDX_W-1:0]     mem_rd_idx_i;
  logic [XLEN-1:0]      mem_rd_data_i;
  logic                 mem_load_i;
  logic [LS_SIZE_W-1:0] mem_load_size_i;
  logic                 mem_load_uns_i;
  logic [1:0]           mem_addr_lo_i;
  logic                 dmem_rsp_vld_i;
  logic [XLEN-1:0]      dmem_rsp_data_i;

  modport master (
    output mem_vld_i, mem_rd_vld_i, mem_rd_idx_i, mem_rd_data_i,
           mem_load_i, mem_load_size_i, mem_load_uns_i, mem_addr_lo_i,
           dmem_rsp_vld_i, dmem_rsp_data_i,
    input  mem_rdy_o
  );

  modport slave (
    input  mem_vld_i, mem_rd_vld_i, mem_rd_idx_i, mem_rd_data_i,
           mem_load_i, mem_load_size_i, mem_load_uns_i, mem_addr_lo_i,
           dmem_rsp_vld_i, dmem_rsp_data_i,
    output mem_rdy_o
  );

endinterface

// File: rtl/k423_wb_stage.sv
// k423_wb_stage
// Purpose: writeback stage of the k423 pipeline. Accepts completed
// instructions from MEM, waits for the data-memory response on loads,
// formats load data (byte/half select plus sign/zero extension) and drives
// the regfile write port, the WB forwarding port and a load-pending hint
// used by ID for hazard stalls.
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   mem_if (slave)     MEM handshake and dmem load response
//   wb_rd_*_o          regfile write port
//   wb_fwd_rd_*_o      WB forwarding port (same cycle as the write)
//   wb_ld_pend_o/idx_o load waiting for its response, and its rd
//   wb_retire_o        one-cycle pulse per retired instruction
module k423_wb_stage #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  k423_wb_stage_if.slave    mem_if,
  output logic              wb_rd_vld_o,
  output logic [IDX_W-1:0]  wb_rd_idx_o,
  output logic [XLEN-1:0]   wb_rd_data_o,
  output logic              wb_fwd_rd_vld_o,
  output logic [IDX_W-1:0]  wb_fwd_rd_idx_o,
  output logic [XLEN-1:0]   wb_fwd_rd_data_o,
  output logic              wb_ld_pend_o,
  output logic [IDX_W-1:0]  wb_ld_pend_idx_o,
  output logic              wb_retire_o
);

  localparam logic [1:0] LS_BYTE = 2'd0;
  localparam logic [1:0] LS_HALF = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WB      = 2'd1,
    S_LD_WAIT = 2'd2
  } state_t;

  state_t           state_q;
  logic             rd_vld_q;
  logic [IDX_W-1:0] idx_q;
  logic [XLEN-1:0]  data_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [1:0]       addr_lo_q;

  logic             accept;
  logic             rd_live;
  logic             commit;

  // Select the addressed byte or half of the raw memory word and extend it.
  // A half uses only addr_lo[1]; misaligned halves never reach this stage.
  // Any size code other than BYTE/HALF passes the word straight through.
  function automatic logic [XLEN-1:0] format_load(
    input logic [XLEN-1:0] raw,
    input logic [1:0]      size,
    input logic            uns,
    input logic [1:0]      addr_lo
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [XLEN-1:0] res;
    b = raw[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? raw[31:16] : raw[15:0];
    case (size)
      LS_BYTE: res = {{(XLEN-8){~uns & b[7]}}, b};
      LS_HALF: res = {{(XLEN-16){~uns & h[15]}}, h};
      default: res = raw;
    endcase
    return res;
  endfunction

  // WB only refuses new work while a load is outstanding, so a commit in
  // S_WB overlaps with accepting the next instruction.
  assign mem_if.mem_rdy_o = (state_q != S_LD_WAIT);
  assign accept           = mem_if.mem_vld_i & mem_if.mem_rdy_o;

  // Single state register: latches the incoming instruction on accept,
  // captures the formatted load data when the response arrives, and
  // returns to idle once a commit cycle has no successor.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      rd_vld_q  <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      addr_lo_q <= '0;
    end else begin
      case (state_q)
        S_LD_WAIT: begin
          if (mem_if.dmem_rsp_vld_i) begin
            data_q  <= format_load(mem_if.dmem_rsp_data_i, size_q, uns_q, addr_lo_q);
            state_q <= S_WB;
          end
        end
        default: begin
          if (accept) begin
            rd_vld_q  <= mem_if.mem_rd_vld_i;
            idx_q     <= mem_if.mem_rd_idx_i;
            data_q    <= mem_if.mem_rd_data_i;
            size_q    <= mem_if.mem_load_size_i;
            uns_q     <= mem_if.mem_load_uns_i;
            addr_lo_q <= mem_if.mem_addr_lo_i;
            state_q   <= mem_if.mem_load_i ? S_LD_WAIT : S_WB;
          end else begin
            state_q   <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Outputs decode registered state only. x0 writes and rd_vld=0 still
  // retire but never write, forward or raise a load-pending hazard.
  assign rd_live = rd_vld_q & (idx_q != '0);
  assign commit  = (state_q == S_WB);

  assign wb_retire_o      = commit;
  assign wb_rd_vld_o      = commit & rd_live;
  assign wb_rd_idx_o      = (commit & rd_live) ? idx_q  : '0;
  assign wb_rd_data_o     = (commit & rd_live) ? data_q : '0;
  assign wb_fwd_rd_vld_o  = wb_rd_vld_o;
  assign wb_fwd_rd_idx_o  = wb_rd_idx_o;
  assign wb_fwd_rd_data_o = wb_rd_data_o;

  assign wb_ld_pend_o     = (state_q == S_LD_WAIT) & rd_live;
  assign wb_ld_pend_idx_o = ((state_q == S_LD_WAIT) & rd_live) ? idx_q : '0;

endmodule

// File: tb/tb_k423_wb_stage.sv
// tb_k423_wb_stage
// Purpose: directed self-checking bench for k423_wb_stage covering reset,
// ALU commits, back-to-back flow, load formatting, x0/rd_vld=0 handling,
// stray responses and reset during an outstanding load.
module tb_k423_wb_stage;

  localparam int XLEN  = 32;
  localparam int IDX_W = 5;

  logic clk_i;
  logic rst_n_i;

  logic              wb_rd_vld_o;
  logic [IDX_W-1:0]  wb_rd_idx_o;
  logic [XLEN-1:0]   wb_rd_data_o;
  logic              wb_fwd_rd_vld_o;
  logic [IDX_W-1:0]  wb_fwd_rd_idx_o;
  logic [XLEN-1:0]   wb_fwd_rd_data_o;
  logic              wb_ld_pend_o;
  logic [IDX_W-1:0]  wb_ld_pend_idx_o;
  logic              wb_retire_o;

  int checks;
  int errors;

  k423_wb_stage_if #(.XLEN(XLEN), .IDX_W(IDX_W)) bus ();

  k423_wb_stage #(.XLEN(XLEN), .IDX_W(IDX_W)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .mem_if           (bus),
    .wb_rd_vld_o      (wb_rd_vld_o),
    .wb_rd_idx_o      (wb_rd_idx_o),
    .wb_rd_data_o     (wb_rd_data_o),
    .wb_fwd_rd_vld_o  (wb_fwd_rd_vld_o),
    .wb_fwd_rd_idx_o  (wb_fwd_rd_idx_o),
    .wb_fwd_rd_data_o (wb_fwd_rd_data_o),
    .wb_ld_pend_o     (wb_ld_pend_o),
    .wb_ld_pend_idx_o (wb_ld_pend_idx_o),
    .wb_retire_o      (wb_retire_o)
  );

  // Free-running 10-unit clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Checks the full output picture of the stage against expected values.
  task automatic checkAll(input string tag, input logic vld, input logic [4:0] idx,
                          input logic [31:0] data, input logic retire, input logic pend,
                          input logic [4:0] pidx, input logic rdy);
    checkOutput({tag, ".wr_vld"},   32'(wb_rd_vld_o),       32'(vld));
    checkOutput({tag, ".wr_idx"},   32'(wb_rd_idx_o),       32'(idx));
    checkOutput({tag, ".wr_data"},  wb_rd_data_o,           data);
    checkOutput({tag, ".fwd_vld"},  32'(wb_fwd_rd_vld_o),   32'(vld));
    checkOutput({tag, ".fwd_idx"},  32'(wb_fwd_rd_idx_o),   32'(idx));
    checkOutput({tag, ".fwd_data"}, wb_fwd_rd_data_o,       data);
    checkOutput({tag, ".retire"},   32'(wb_retire_o),       32'(retire));
    checkOutput({tag, ".pend"},     32'(wb_ld_pend_o),      32'(pend));
    checkOutput({tag, ".pend_idx"}, 32'(wb_ld_pend_idx_o),  32'(pidx));
    checkOutput({tag, ".rdy"},      32'(bus.mem_rdy_o),     32'(rdy));
  endtask

  // Drives the MEM-side instruction fields.
  task automatic applyStimulus(input logic vld, input logic rd_vld, input logic [4:0] idx,
                               input logic [31:0] data, input logic load, input logic [1:0] size,
                               input logic uns, input logic [1:0] addr_lo);
    bus.mem_vld_i       = vld;
    bus.mem_rd_vld_i    = rd_vld;
    bus.mem_rd_idx_i    = idx;
    bus.mem_rd_data_i   = data;
    bus.mem_load_i      = load;
    bus.mem_load_size_i = size;
    bus.mem_load_uns_i  = uns;
    bus.mem_addr_lo_i   = addr_lo;
  endtask

  // Advances one clock; outputs are sampled 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issues a load, waits `waitCycles` pending cycles, delivers the response
  // and checks the commit cycle and the return to idle.
  task automatic doLoad(input string tag, input logic rd_vld, input logic [4:0] idx,
                        input logic [1:0] size, input logic uns, input logic [1:0] addr_lo,
                        input logic [31:0] rsp, input int waitCycles, input logic [31:0] expData);
    logic       live;
    logic [4:0] pidx;
    live = rd_vld && (idx != 5'd0);
    pidx = live ? idx : 5'd0;
    applyStimulus(1'b1, rd_vld, idx, 32'hDEAD_BEEF, 1'b1, size, uns, addr_lo);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0);
    for (int i = 0; i < waitCycles; i++) begin
      checkAll({tag, ".wait"}, 1'b0, 5'd0, 32'h0, 1'b0, live, pidx, 1'b0);
      if (i < waitCycles - 1) tick();
    end
    bus.dmem_rsp_vld_i  = 1'b1;
    bus.dmem_rsp_data_i = rsp;
    tick();
    bus.dmem_rsp_vld_i  = 1'b0;
    bus.dmem_rsp_data_i = 32'h0;
    checkAll({tag, ".commit"}, live, live ? idx : 5'd0, live ? expData : 32'h0,
             1'b1, 1'b0, 5'd0, 1'b1);
    tick();
    checkAll({tag, ".idle"}, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    checks  = 0;
    errors  = 0;
    rst_n_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0);
    bus.dmem_rsp_vld_i  = 1'b0;
    bus.dmem_rsp_data_i = 32'h0;

    #12;
    checkAll("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
    rst_n_i = 1'b1;
    tick();
    checkAll("post_reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);

    applyStimulus(1'b1, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0);
    checkAll("add_x5", 1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b0, 5'd0, 1'b1);
    tick();
    checkAll("add_x5_after", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);

    applyStimulus(1'b1, 1'b1, 5'd1, 32'd1, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    checkAll("b2b_x1", 1'b1, 5'd1, 32'd1, 1'b1, 1'b0, 5'd0, 1'b1);
    applyStimulus(1'b1, 1'b1, 5'd2, 32'd2, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    checkAll("b2b_x2", 1'b1, 5'd2, 32'd2, 1'b1, 1'b0, 5'd0, 1'b1);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'd3, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0);
    checkAll("b2b_x3", 1'b1, 5'd3, 32'd3, 1'b1, 1'b0, 5'd0, 1'b1);
    tick();
    checkAll("b2b_end", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);

    doLoad("lb",  1'b1, 5'd7,  2'd0, 1'b0, 2'd3, 32'h80FF_0000, 2, 32'hFFFF_FF80);
    doLoad("lbu", 1'b1, 5'd7,  2'd0, 1'b1, 2'd3, 32'h80FF_0000, 2, 32'h0000_0080);
    doLoad("lb1", 1'b1, 5'd10, 2'd0, 1'b0, 2'd1, 32'h1234_5678, 1, 32'h0000_0056);
    doLoad("lh",  1'b1, 5'd11, 2'd1, 1'b0, 2'd2, 32'h8001_7FFF, 1, 32'hFFFF_8001);
    doLoad("lhu", 1'b1, 5'd12, 2'd1, 1'b1, 2'd0, 32'h8001_7FFF, 1, 32'h0000_7FFF);
    doLoad("lh0", 1'b1, 5'd12, 2'd1, 1'b0, 2'd1, 32'h8001_F00F, 1, 32'hFFFF_F00F);
    doLoad("lw",  1'b1, 5'd13, 2'd2, 1'b1, 2'd3, 32'h8001_7FFF, 1, 32'h8001_7FFF);
    doLoad("ld_x0",   1'b1, 5'd0, 2'd2, 1'b0, 2'd0, 32'h5555_AAAA, 1, 32'h0);
    doLoad("ld_nord", 1'b0, 5'd9, 2'd2, 1'b0, 2'd0, 32'h5555_AAAA, 2, 32'h0);

    applyStimulus(1'b1, 1'b1, 5'd0, 32'hCAFE_F00D, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    checkAll("alu_x0", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 5'd9, 32'hCAFE_F00D, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0);
    checkAll("alu_nord", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1);
    tick();

    bus.dmem_rsp_vld_i  = 1'b1;
    bus.dmem_rsp_data_i = 32'h1111_2222;
    tick();
    checkAll("stray_rsp", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
    applyStimulus(1'b1, 1'b1, 5'd4, 32'h0000_00AB, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    bus.dmem_rsp_vld_i  = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0);
    checkAll("stray_rsp_alu", 1'b1, 5'd4, 32'h0000_00AB, 1'b1, 1'b0, 5'd0, 1'b1);
    tick();

    applyStimulus(1'b1, 1'b1, 5'd8, 32'h0, 1'b1, 2'd2, 1'b0, 2'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0);
    checkAll("rst_ld_wait", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd8, 1'b0);
    #2;
    rst_n_i = 1'b0;
    #1;
    checkAll("rst_ld_in_reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
    #1;
    rst_n_i = 1'b1;
    bus.dmem_rsp_vld_i  = 1'b1;
    bus.dmem_rsp_data_i = 32'h7777_7777;
    tick();
    bus.dmem_rsp_vld_i  = 1'b0;
    bus.dmem_rsp_data_i = 32'h0;
    checkAll("rst_ld_rsp", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
    tick();
    checkAll("rst_ld_after", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
